alu_seq_unit: RTL

//  Parametrised sequential ALU; successor to the 8-bit combinational add/sub/xor/shift ALU.

---
 rtl/alu_seq_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_seq_unit.sv
// Sequential ALU with a start/ready handshake and a one-cycle done pulse.
// ADD/SUB/XOR complete at once. SHL shifts one bit per cycle. MUL uses WIDTH shift-add steps.
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           operation,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 borrow,
  output logic                 zero,
  output logic                 err
);

  localparam int SHW = $clog2(WIDTH) + 1;
  localparam logic [SHW-1:0]   FULL_STEPS = SHW'(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_B    = WIDTH'(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_XOR = 3'b010,
    OP_SHL = 3'b011,
    OP_MUL = 3'b100
  } op_t;

  state_t             state;
  op_t                op_r;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mpl;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] fast_res;
  logic               fast_carry, fast_borrow, fast_err, multi;
  logic [SHW-1:0]     steps;
  logic [2*WIDTH-1:0] acc_nxt, mcand_nxt, exec_res;

  always_comb begin
    sum         = {1'b0, a} + {1'b0, b};
    fast_res    = '0;
    fast_carry  = 1'b0;
    fast_borrow = 1'b0;
    fast_err    = 1'b0;
    multi       = 1'b0;
    steps       = '0;
    case (operation)
      OP_ADD: begin
        fast_res[WIDTH-1:0] = sum[WIDTH-1:0];
        fast_carry          = sum[WIDTH];
      end
      OP_SUB: begin
        fast_res[WIDTH-1:0] = a - b;
        fast_borrow         = (a < b);
      end
      OP_XOR: fast_res[WIDTH-1:0] = a ^ b;
      OP_SHL: begin
        if (b == '0) begin
          fast_res[WIDTH-1:0] = a;
        end else begin
          multi = 1'b1;
          steps = (b >= WIDTH_B) ? FULL_STEPS : SHW'(b);
        end
      end
      OP_MUL: begin
        multi = 1'b1;
        steps = FULL_STEPS;
      end
      default: fast_err = 1'b1;
    endcase
  end

  // SHL reuses the multiplicand register; its low WIDTH bits hold the value being shifted.
  always_comb begin
    acc_nxt   = acc + (mpl[0] ? mcand : '0);
    mcand_nxt = mcand << 1;
    exec_res  = (op_r == OP_MUL) ? acc_nxt : {{WIDTH{1'b0}}, mcand_nxt[WIDTH-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= OP_ADD;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mpl    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op_t'(operation);
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a};
            mpl   <= b;
            cnt   <= steps;
            ready <= 1'b0;
            if (multi) begin
              state <= EXEC;
            end else begin
              state  <= DONE;
              done   <= 1'b1;
              result <= fast_res;
              carry  <= fast_carry;
              borrow <= fast_borrow;
              zero   <= (fast_res == '0);
              err    <= fast_err;
            end
          end
        end
        EXEC: begin
          acc   <= acc_nxt;
          mcand <= mcand_nxt;
          mpl   <= mpl >> 1;
          cnt   <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= exec_res;
            carry  <= (op_r == OP_SHL) ? mcand[WIDTH-1] : 1'b0;
            borrow <= 1'b0;
            zero   <= (exec_res == '0);
            err    <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
